// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: stall/flush/redirect controller for the five-stage pipeline.
// It also owns the multiply/divide busy counter, which holds MDU-dependent
// instructions in D until the result is ready.
// Optional feature macro: PIPE_PERF_CNT_EN adds the stall_cycles and
// flush_events performance counters.
module pipe_flow_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req_d,
  input  logic        mdu_use_d,
  input  logic        mdu_start_e,
  input  logic        mdu_div_e,
  input  logic [4:0]  exc_code_m,
  input  logic        int_req,
  input  logic        eret_m,
  input  logic [31:0] epc,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        exc_take,
  output logic        mdu_go,
  output logic        mdu_busy,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic [3:0]  mdu_count
);

  typedef enum logic {IDLE, BUSY} mdu_state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  mdu_state_e state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       busy;
  logic       exc;
  logic       stall;

  assign busy  = (state_q == BUSY);
  assign exc   = (exc_code_m != 5'd31) | int_req;
  assign stall = stall_req_d | (mdu_use_d & (busy | mdu_start_e));

  // Registered MDU status, held at zero while reset is asserted.
  assign mdu_busy  = reset & busy;
  assign mdu_count = reset ? count_q : '0;

  // Pipeline control decode: reset, then exception, then ERET, then stall.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    exc_take    = 1'b0;
    mdu_go      = 1'b0;
    if (!reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (exc) begin
      exc_take    = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = EXC_HANDLER;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = 1'b1;
    end else if (eret_m) begin
      pc_redirect = 1'b1;
      pc_target   = epc;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = 1'b1;
    end else begin
      stall_f = stall;
      stall_d = stall;
      flush_e = stall;
      mdu_go  = mdu_start_e;
    end
  end

  // MDU busy FSM next state; exceptions and ERET never cancel a running op.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (mdu_go) begin
          state_d = BUSY;
          count_d = mdu_div_e ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (count_q == 4'd1) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // MDU state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

  // Performance counters: PC-hold cycles and redirect cycles, wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_f)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (pc_redirect) flush_events_q <= flush_events_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed scenarios plus a
// randomized run against a behavioural model.
module tb_pipe_flow_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_req_d;
  logic        mdu_use_d;
  logic        mdu_start_e;
  logic        mdu_div_e;
  logic [4:0]  exc_code_m;
  logic        int_req;
  logic        eret_m;
  logic [31:0] epc;
  logic        stall_f, stall_d, flush_d, flush_e, flush_m;
  logic        pc_redirect, exc_take, mdu_go, mdu_busy;
  logic [31:0] pc_target;
  logic [3:0]  mdu_count;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  int checks = 0;
  int fails  = 0;

  pipe_flow_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .EXC_HANDLER(HANDLER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_req_d(stall_req_d),
    .mdu_use_d  (mdu_use_d),
    .mdu_start_e(mdu_start_e),
    .mdu_div_e  (mdu_div_e),
    .exc_code_m (exc_code_m),
    .int_req    (int_req),
    .eret_m     (eret_m),
    .epc        (epc),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .exc_take   (exc_take),
    .mdu_go     (mdu_go),
    .mdu_busy   (mdu_busy),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
`endif
    .mdu_count  (mdu_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    stall_req_d = 1'b0;
    mdu_use_d   = 1'b0;
    mdu_start_e = 1'b0;
    mdu_div_e   = 1'b0;
    exc_code_m  = 5'd31;
    int_req     = 1'b0;
    eret_m      = 1'b0;
    epc         = 32'h0;
  endtask

  // Inputs change just after a negedge; outputs are sampled 1 time unit later.
  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    mdu_start_e = 1'b1;
    mdu_div_e   = 1'b1;
    #1;
    checks++;
    if (mdu_go !== 1'b1) begin fails++; $display("FAIL rst_go: got %b want 1", mdu_go); end
    @(negedge clk);
    set_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mdu_count !== 4'd7 || mdu_busy !== 1'b1) begin
      fails++; $display("FAIL rst_pre_count: got %0d busy %b want 7 busy 1", mdu_count, mdu_busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({flush_d, flush_e, flush_m} !== 3'b111 || {stall_f, stall_d, pc_redirect, exc_take, mdu_go} !== 5'b0 ||
          pc_target !== 32'h0 || mdu_busy !== 1'b0 || mdu_count !== 4'd0) begin
        fails++;
        $display("FAIL rst_hold: flush %b%b%b stall %b%b redir %b take %b go %b tgt %h busy %b cnt %0d want flush 111 rest 0",
                 flush_d, flush_e, flush_m, stall_f, stall_d, pc_redirect, exc_take, mdu_go, pc_target, mdu_busy, mdu_count);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || mdu_count !== 4'd0 || flush_e !== 1'b0) begin
      fails++; $display("FAIL rst_after: busy %b cnt %0d flush_e %b want 0 0 0", mdu_busy, mdu_count, flush_e);
    end
    @(negedge clk);
  endtask

  // mult latency, first without a D dependency, then with one.
  task automatic test_mult();
    for (int dep = 0; dep < 2; dep++) begin
      int n_stall = 0;
      int n_busy  = 0;
      set_idle();
      mdu_start_e = 1'b1;
      mdu_use_d   = (dep == 1);
      for (int i = 0; i < 20; i++) begin
        #1;
        if (stall_f) n_stall++;
        if (mdu_busy) n_busy++;
        @(negedge clk);
        mdu_start_e = 1'b0;
      end
      checks++;
      if (n_busy != 5) begin fails++; $display("FAIL mult_busy dep=%0d: got %0d want 5", dep, n_busy); end
      checks++;
      if (n_stall != (dep == 1 ? 6 : 0)) begin
        fails++; $display("FAIL mult_stall dep=%0d: got %0d want %0d", dep, n_stall, dep == 1 ? 6 : 0);
      end
    end
    set_idle();
  endtask

  task automatic test_div_exc();
    int exp_cnt;
    set_idle();
    mdu_start_e = 1'b1;
    mdu_div_e   = 1'b1;
    @(negedge clk);
    set_idle();
    repeat (2) @(negedge clk);
    exc_code_m = 5'd4;
    mdu_use_d  = 1'b1;
    #1;
    checks++;
    if (exc_take !== 1'b1 || pc_redirect !== 1'b1 || pc_target !== HANDLER ||
        {flush_d, flush_e, flush_m} !== 3'b111 || stall_f !== 1'b0 || mdu_count !== 4'd8) begin
      fails++;
      $display("FAIL div_exc: take %b redir %b tgt %h flush %b%b%b stall %b cnt %0d want 1 1 00004180 111 0 8",
               exc_take, pc_redirect, pc_target, flush_d, flush_e, flush_m, stall_f, mdu_count);
    end
    @(negedge clk);
    set_idle();
    exp_cnt = 7;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (mdu_count !== 4'(exp_cnt) || mdu_busy !== (exp_cnt != 0)) begin
        fails++; $display("FAIL div_count step %0d: got %0d busy %b want %0d", i, mdu_count, mdu_busy, exp_cnt);
      end
      @(negedge clk);
      if (exp_cnt > 0) exp_cnt--;
    end
  endtask

  task automatic test_exc_start();
    set_idle();
    exc_code_m  = 5'd10;
    mdu_start_e = 1'b1;
    #1;
    checks++;
    if (mdu_go !== 1'b0 || pc_redirect !== 1'b1 || exc_take !== 1'b1) begin
      fails++; $display("FAIL exc_start: go %b redir %b take %b want 0 1 1", mdu_go, pc_redirect, exc_take);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || mdu_count !== 4'd0) begin
      fails++; $display("FAIL exc_start_idle: busy %b cnt %0d want 0 0", mdu_busy, mdu_count);
    end
    @(negedge clk);
  endtask

  task automatic test_eret();
    set_idle();
    eret_m      = 1'b1;
    epc         = 32'h0000_3010;
    stall_req_d = 1'b1;
    #1;
    checks++;
    if (pc_target !== 32'h0000_3010 || stall_f !== 1'b0 || flush_e !== 1'b1 || exc_take !== 1'b0 || pc_redirect !== 1'b1) begin
      fails++; $display("FAIL eret: tgt %h stall %b flush_e %b take %b redir %b want 00003010 0 1 0 1",
                        pc_target, stall_f, flush_e, exc_take, pc_redirect);
    end
    @(negedge clk);
    int_req = 1'b1;
    #1;
    checks++;
    if (pc_target !== HANDLER || exc_take !== 1'b1 || stall_f !== 1'b0) begin
      fails++; $display("FAIL eret_int: tgt %h take %b stall %b want 00004180 1 0", pc_target, exc_take, stall_f);
    end
    @(negedge clk);
    set_idle();
  endtask

  // Random traffic against a model holding only the remaining MDU busy cycles.
  task automatic test_random();
    int remaining = 0;
    logic [8:0]  exp_ctrl, got_ctrl;
    logic [31:0] exp_tgt;
    logic [3:0]  exp_cnt;
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit has_exc, is_stall, go;
      reset       = ($urandom_range(0, 99) >= 3);
      stall_req_d = ($urandom_range(0, 99) < 25);
      mdu_use_d   = ($urandom_range(0, 99) < 30);
      mdu_start_e = (remaining == 0) && ($urandom_range(0, 99) < 25);
      mdu_div_e   = 1'($urandom_range(0, 1));
      exc_code_m  = ($urandom_range(0, 99) < 85) ? 5'd31 : 5'($urandom_range(0, 31));
      int_req     = ($urandom_range(0, 99) < 5);
      eret_m      = ($urandom_range(0, 99) < 8);
      epc         = $urandom;
      has_exc  = (exc_code_m != 5'd31) || int_req;
      is_stall = stall_req_d || (mdu_use_d && (remaining > 0 || mdu_start_e));
      go = 1'b0;
      // ctrl = {stall_f, stall_d, flush_d, flush_e, flush_m, pc_redirect, exc_take, mdu_go, mdu_busy}
      if (!reset) begin
        exp_ctrl = 9'b00_111_0000;
        exp_tgt  = 32'h0;
        exp_cnt  = 4'd0;
      end else begin
        exp_cnt = 4'(remaining);
        if (has_exc) begin
          exp_ctrl = {2'b00, 3'b111, 1'b1, 1'b1, 1'b0, remaining > 0};
          exp_tgt  = HANDLER;
        end else if (eret_m) begin
          exp_ctrl = {2'b00, 3'b111, 1'b1, 1'b0, 1'b0, remaining > 0};
          exp_tgt  = epc;
        end else begin
          go = mdu_start_e;
          exp_ctrl = {is_stall, is_stall, 1'b0, is_stall, 1'b0, 1'b0, 1'b0, go, remaining > 0};
          exp_tgt  = 32'h0;
        end
      end
      #1;
      got_ctrl = {stall_f, stall_d, flush_d, flush_e, flush_m, pc_redirect, exc_take, mdu_go, mdu_busy};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        fails++; $display("FAIL rand_ctrl cyc %0d: got %b want %b", cyc, got_ctrl, exp_ctrl);
      end
      checks++;
      if (pc_target !== exp_tgt) begin
        fails++; $display("FAIL rand_target cyc %0d: got %h want %h", cyc, pc_target, exp_tgt);
      end
      checks++;
      if (mdu_count !== exp_cnt) begin
        fails++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, mdu_count, exp_cnt);
      end
      if (!reset)             remaining = 0;
      else if (remaining > 0) remaining = remaining - 1;
      else if (go)            remaining = mdu_div_e ? 10 : 5;
      @(negedge clk);
    end
    reset = 1'b1;
    set_idle();
    repeat (12) @(negedge clk);
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      fails++; $display("FAIL perf_reset: stall %0d flush %0d want 0 0", stall_cycles, flush_events);
    end
    stall_req_d = 1'b1;
    repeat (4) @(negedge clk);
    stall_req_d = 1'b0;
    exc_code_m  = 5'd5;
    repeat (2) @(negedge clk);
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 32'd4 || flush_events !== 32'd2) begin
      fails++; $display("FAIL perf_counts: stall %0d flush %0d want 4 2", stall_cycles, flush_events);
    end
  endtask
`endif

  initial begin
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_mult();
    test_div_exc();
    test_exc_start();
    test_eret();
    test_random();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Central stall/flush and redirect controller for the five-stage pipeline. It watches the D-stage hazard requests, the M-stage exception code and ERET, and a pending-interrupt line. It drives the enable and synchronous-clear controls of the F/D/E/M/W pipeline registers and the PC redirect. It also owns the multiply/divide busy counter, so MDU-dependent instructions in D are held until the result is ready.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- EXC_HANDLER, 32'h0000_4180, exception/interrupt entry PC

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pipeline clock, all state on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- stall_req_d  in  1  load-use / forwarding hazard detected in D
- mdu_use_d  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- mdu_start_e  in  1  mult/multu/div/divu valid in E this cycle
- mdu_div_e  in  1  qualifies mdu_start_e: 1 = divide, 0 = multiply
- exc_code_m  in  5  exception code carried in the M register; 5'd31 = none
- int_req  in  1  interrupt pending and enabled (from CP0)
- eret_m  in  1  ERET in M
- epc  in  32  CP0 EPC
- stall_f  out  1  hold PC
- stall_d  out  1  hold D register
- flush_d, flush_e, flush_m  out  1 each  synchronous clear of D/E/M registers (clear to reset contents; exc_code to 31)
- pc_redirect  out  1  PC loads pc_target at next edge
- pc_target  out  32  redirect address
- exc_take  out  1  CP0 commits exception/interrupt this cycle
- mdu_go  out  1  gated start to MDU
- mdu_busy  out  1  MDU counter nonzero
- mdu_count  out  4  remaining busy cycles

## Operation
- exc = (exc_code_m != 5'd31) | int_req.
- Priority per cycle: exc > eret_m > stall. Exactly one of the three branches below applies.
- exc: exc_take=1, pc_redirect=1, pc_target=EXC_HANDLER, flush_d=flush_e=flush_m=1, stall_f=stall_d=0, mdu_go=0.
- eret_m (no exc): pc_redirect=1, pc_target=epc, flush_d=flush_e=flush_m=1, exc_take=0, mdu_go=0.
- Otherwise, stall = stall_req_d | (mdu_use_d & (mdu_busy | mdu_start_e)).
  - When stall=1: stall_f=stall_d=1, flush_e=1 (bubble), flush_d=flush_m=0.
  - mdu_go=mdu_start_e. E is not stalled, so the start still proceeds.
- MDU FSM, states IDLE and BUSY:
  - IDLE: on mdu_go, load mdu_count with DIV_CYCLES if mdu_div_e else MULT_CYCLES, then go to BUSY.
  - BUSY: decrement each cycle. When mdu_count == 1, go to IDLE with count 0. mdu_go is never asserted in BUSY, because a new MDU instruction in D is stalled.
  - An exception or ERET during BUSY does not cancel the count, since the running op is older than M.
- mdu_busy = (state == BUSY). mdu_count is 0 in IDLE.
- pc_target = 0 when pc_redirect = 0.

## Timing
- All control outputs except mdu_busy and mdu_count are combinational from inputs and state, and take effect at the next posedge.
- MDU latency:
  - Start sampled at edge T; mdu_busy is high for edges T+1 through T+N (N = MULT_CYCLES or DIV_CYCLES).
  - A dependent mfhi in D is released in the cycle after mdu_busy falls.
- Reset (reset=0 at an edge):
  - State goes to IDLE, mdu_count=0, mdu_busy=0.
  - While reset is low, all outputs are forced to 0 except flush_d=flush_e=flush_m=1.
  - Reset mid-BUSY aborts the count.
- Simultaneous events:
  - exc with mdu_start_e: the start is dropped (mdu_go=0) and the FSM stays IDLE.
  - exc with eret_m: the exception wins, target EXC_HANDLER.
  - exc with stall_req_d: no stall, flush only.

## Configuration
- PIPE_PERF_CNT_EN defined: adds two outputs:
  - stall_cycles (32): counts cycles with stall_f=1.
  - flush_events (32): counts cycles with pc_redirect=1.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

## Test plan
- Reset low for 2 cycles during BUSY with mdu_count=7: next cycle mdu_busy=0, mdu_count=0, flush_d/e/m=1 while reset low.
- mult start (mdu_div_e=0) with no D dependency: mdu_busy high exactly 5 cycles. With mdu_use_d=1 from the start cycle, stall_f high for 6 cycles (the start cycle plus 5), then released.
- div start, then exc_code_m=5'd4 arrives 3 cycles later: exc_take=1, pc_target=32'h0000_4180, flush_d/e/m=1, and mdu_count continues 7,6,… to 0.
- exc_code_m=5'd10 in the same cycle as mdu_start_e=1: mdu_go=0, mdu_busy stays 0, pc_redirect=1.
- eret_m=1 with epc=32'h0000_3010 and stall_req_d=1: pc_target=32'h0000_3010, stall_f=0, flush_e=1. Repeat with int_req=1 as well: pc_target=32'h0000_4180.
- With PIPE_PERF_CNT_EN: 4 load-use stall cycles plus 2 exceptions give stall_cycles=4, flush_events=2.
